// File: rtl/mmio_out_pkg.sv
// Shared register map, STATUS/CTRL bit positions and address decode for mmio_out_bridge.
// The toggle-alias region is decoded here and enabled in the top by MMIO_TOGGLE_ALIAS_EN.
package mmio_out_pkg;

    localparam logic [7:0] OFF_OUT_BASE    = 8'h00;
    localparam logic [7:0] OFF_TX_DATA     = 8'h40;
    localparam logic [7:0] OFF_STATUS      = 8'h44;
    localparam logic [7:0] OFF_CTRL        = 8'h48;
    localparam logic [7:0] OFF_TOGGLE_BASE = 8'h80;

    localparam int ST_FULL_BIT     = 0;
    localparam int ST_EMPTY_BIT    = 1;
    localparam int ST_OVF_BIT      = 2;
    localparam int ST_COUNT_LSB    = 8;

    localparam int CTRL_TX_EN_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam logic [1:0] CTRL_RESET = 2'b01;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_TX_DATA,
        SEL_STATUS,
        SEL_CTRL,
        SEL_TOGGLE
    } reg_sel_e;

    // Byte-address bits [1:0] are ignored; everything is decoded on word offsets.
    function automatic reg_sel_e decode_sel(input logic [7:0] addr, input int num_out);
        logic [7:0] word_addr;
        word_addr  = {addr[7:2], 2'b00};
        decode_sel = SEL_NONE;
        if (word_addr >= OFF_TOGGLE_BASE) begin
            if (int'((word_addr - OFF_TOGGLE_BASE) >> 2) < num_out)
                decode_sel = SEL_TOGGLE;
        end else if (word_addr == OFF_TX_DATA) begin
            decode_sel = SEL_TX_DATA;
        end else if (word_addr == OFF_STATUS) begin
            decode_sel = SEL_STATUS;
        end else if (word_addr == OFF_CTRL) begin
            decode_sel = SEL_CTRL;
        end else if (word_addr < OFF_TX_DATA) begin
            if (int'((word_addr - OFF_OUT_BASE) >> 2) < num_out)
                decode_sel = SEL_OUT;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/count; a push while full is ignored (the caller
// flags the overflow). DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: storage has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_out_bridge.sv
// Memory-mapped output registers plus a FIFO-buffered byte transmit channel with IRQ.
// Define MMIO_TOGGLE_ALIAS_EN to enable the write-1-to-toggle alias at 0x80+4*i.
module mmio_out_bridge
    import mmio_out_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_OUT    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [7:0]                  bus_addr,
    input  logic [DATA_W-1:0]           bus_wdata,
    input  logic                        bus_we,
    input  logic                        bus_re,
    output logic [DATA_W-1:0]           bus_rdata,
    output logic                        bus_ack,
    output logic [NUM_OUT*DATA_W-1:0]   out_value,
    output logic [7:0]                  tx_Data,
    output logic                        tx_DataValid,
    input  logic                        tx_Ready,
    output logic                        irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    reg_sel_e         w_sel;
    logic [2:0]       w_idx;
    logic             w_wr_out;
    logic             w_wr_tog;
    logic             w_wr_status;
    logic             w_wr_ctrl;
    logic             w_push;

    logic [7:0]       w_fifo_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_accept;
    logic             w_load;

    logic [DATA_W-1:0] r_out [NUM_OUT];
    logic [1:0]        r_ctrl;
    logic              r_ovf;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic              r_irq;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rdata;

    assign w_sel       = decode_sel(bus_addr, NUM_OUT);
    assign w_idx       = bus_addr[4:2];
    assign w_wr_out    = bus_we && (w_sel == SEL_OUT);
    assign w_wr_status = bus_we && (w_sel == SEL_STATUS);
    assign w_wr_ctrl   = bus_we && (w_sel == SEL_CTRL);
    assign w_push      = bus_we && (w_sel == SEL_TX_DATA);

`ifdef MMIO_TOGGLE_ALIAS_EN
    assign w_wr_tog = bus_we && (w_sel == SEL_TOGGLE);
`else
    assign w_wr_tog = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (bus_wdata[7:0]),
        .i_pop   (w_load),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // The stage refills in the same cycle its byte is accepted, sustaining one byte per clock.
    assign w_accept = r_tx_valid && tx_Ready;
    assign w_load   = r_ctrl[CTRL_TX_EN_BIT] && !w_fifo_empty && (!r_tx_valid || w_accept);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else if (w_load) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_fifo_data;
        end else if (w_accept) begin
            r_tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_OUT; i++)
                r_out[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_wr_out && (w_idx == 3'(i)))
                    r_out[i] <= bus_wdata;
                else if (w_wr_tog && (w_idx == 3'(i)))
                    r_out[i] <= r_out[i] ^ bus_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ctrl <= CTRL_RESET;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr_ctrl)
                r_ctrl <= bus_wdata[1:0];
            if (w_push && w_fifo_full)
                r_ovf <= 1'b1;
            else if (w_wr_status && bus_wdata[ST_OVF_BIT])
                r_ovf <= 1'b0;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_status                              = '0;
        w_status[ST_FULL_BIT]                 = w_fifo_full;
        w_status[ST_EMPTY_BIT]                = w_fifo_empty;
        w_status[ST_OVF_BIT]                  = r_ovf;
        w_status[ST_COUNT_LSB +: CNT_W]       = w_fifo_count;
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SEL_OUT: begin
                for (int i = 0; i < NUM_OUT; i++)
                    if (w_idx == 3'(i))
                        w_rdata = r_out[i];
            end
            SEL_STATUS: w_rdata = w_status;
            SEL_CTRL: begin
                w_rdata[CTRL_TX_EN_BIT]  = r_ctrl[CTRL_TX_EN_BIT];
                w_rdata[CTRL_IRQ_EN_BIT] = r_ctrl[CTRL_IRQ_EN_BIT];
            end
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ack   <= bus_we || bus_re;
            r_rdata <= bus_re ? w_rdata : '0;
            r_irq   <= r_ctrl[CTRL_IRQ_EN_BIT] && w_fifo_empty && !r_tx_valid;
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_value[g*DATA_W +: DATA_W] = r_out[g];
    end

    assign bus_ack      = r_ack;
    assign bus_rdata    = r_rdata;
    assign tx_Data      = r_tx_data;
    assign tx_DataValid = r_tx_valid;
    assign irq          = r_irq;

endmodule

// File: doc/mmio_out_bridge.md
Name: mmio_out_bridge

Overview:
- Parametrised successor to the single-value, single-byte CPU output path: memory-mapped peripheral on the multi-cycle core's data bus.
- Provides NUM_OUT general output registers, generalising toggle_value.
- Provides a FIFO-buffered byte transmit channel with valid/ready backpressure, generalising tx_Data/tx_DataValid.
- Sits between the core's data-memory port and the UART transmitter and board outputs.

Parameters:
- DATA_W, 32, bus and output-register width (>= 16).
- NUM_OUT, 2, number of output registers (1..8).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- bus_addr  in  8  byte offset within peripheral; bits[1:0] ignored
- bus_wdata  in  DATA_W  write data
- bus_we  in  1  write strobe, one-cycle pulse
- bus_re  in  1  read strobe, one-cycle pulse; never asserted together with bus_we
- bus_rdata  out  DATA_W  registered read data
- bus_ack  out  1  one-cycle acknowledge for any access
- out_value  out  NUM_OUT*DATA_W  concatenated output registers, OUT_0 in LSBs
- tx_Data  out  8  transmit byte
- tx_DataValid  out  1  transmit byte valid
- tx_Ready  in  1  consumer accepts byte when high with tx_DataValid
- irq  out  1  level interrupt

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values: all outputs 0; FIFO empty; CTRL = 0x1 (tx_en=1, irq_en=0); overflow flag 0.
- Register map:
  - 0x00+4*i OUT_i, RW, i < NUM_OUT.
  - 0x40 TX_DATA, WO; pushes wdata[7:0]; reads return 0.
  - 0x44 STATUS, RO except bit2:
    - bit0 full, bit1 empty, bit2 overflow (W1C).
    - bits[15:8] FIFO count.
    - Other bits 0.
  - 0x48 CTRL, RW:
    - bit0 tx_en.
    - bit1 irq_en.
- Unmapped offsets: reads return 0; writes are ignored but still acked.
- Bus timing: bus_ack asserts exactly the cycle after the strobe. bus_rdata is valid in the ack cycle and 0 otherwise. Register writes are visible on out_value the cycle after the strobe.
- Push while full: byte dropped, overflow set, count unchanged.
- FIFO pop feeds a one-entry output stage holding tx_Data/tx_DataValid.
- Output stage loads when tx_en=1, FIFO non-empty, and (stage empty OR tx_Ready && tx_DataValid this cycle). Consumption and reload may occur back-to-back, giving one byte per cycle.
- tx_Data stays stable while tx_DataValid=1 && tx_Ready=0.
- Clearing tx_en stops loads. A byte already in the stage remains valid until accepted.
- Push and pop in the same cycle: count unchanged. A push into an empty FIFO is poppable the next cycle, so first-byte latency is write strobe to tx_DataValid = 2 cycles.
- Count is measured in FIFO entries only, excluding the output stage. Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- irq = irq_en && FIFO empty && !tx_DataValid. It is registered and updates one cycle after the condition changes.
- Reset asserted mid-transfer: tx_DataValid drops immediately (asynchronously) and FIFO contents are lost.

Optional Feature:
- Macro MMIO_TOGGLE_ALIAS_EN.
- Defined: alias region 0x80+4*i, write-only.
  - Writing to it XORs bus_wdata into OUT_i (write-1-to-toggle).
  - Reads of the alias return 0.
  - A same-cycle write to OUT_i is impossible (single strobe).
- Undefined: 0x80.. is unmapped (reads 0, writes ignored, acked).

Decomposition:
- Package mmio_out_pkg: offset constants OFF_OUT_BASE, OFF_TX_DATA, OFF_STATUS, OFF_CTRL, OFF_TOGGLE_BASE, and STATUS/CTRL bit-index constants.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop, full/empty/count, no overflow write-through.
- Top handles decode, registers, output stage and irq.

Test Plan:
- Write 0xDEADBEEF to 0x04 with NUM_OUT=2 -> out_value[63:32]=0xDEADBEEF next cycle; bus_ack pulses once; read 0x04 returns 0xDEADBEEF.
- Push 0x41,0x42,0x43 with tx_Ready=1 held -> tx_DataValid high 2 cycles after first strobe; bytes appear in order on consecutive accept cycles; STATUS.empty=1 afterwards.
- tx_Ready=0, push 9 bytes with FIFO_DEPTH=8 -> first byte held in stage, count=7; 9th push accepted (count=8, full=1); 10th push sets overflow=1 and is dropped; W1C 0x4 to 0x44 clears it.
- CTRL=0x2 (tx_en=0, irq_en=1), push 1 byte -> tx_DataValid stays 0, irq=0; write CTRL=0x3 -> byte emitted; irq=1 one cycle after acceptance.
- Assert resetn low mid-stream with tx_DataValid=1 -> outputs 0 immediately; after release, STATUS reads 0x0000_0002 and out_value=0.
- With MMIO_TOGGLE_ALIAS_EN: OUT_0=0x0F, write 0xFF to 0x80 -> OUT_0=0xF0; without the macro, same write leaves OUT_0=0x0F and still acks.
